// File: rtl/cdr_pkg.sv
// Shared types and the phase-step rule for the 4x-oversampled CDR phase controller.
package cdr_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } cdr_state_t;

    // Pending adjustment to the bit stream caused by a wrapping phase step.
    typedef enum logic [1:0] {
        SLIP_NONE   = 2'd0,
        SLIP_DROP   = 2'd1,
        SLIP_DOUBLE = 2'd2
    } slip_t;

    localparam phase_t RESET_PHASE = 2'd2;
    localparam int     STABLE_W    = 3;

    // One step toward target: forward for a distance of 1 or 2, backward for 3.
    function automatic phase_t phase_step(input phase_t phase, input phase_t target);
        phase_t diff;
        diff = target - phase;
        case (diff)
            2'd0:    return phase;
            2'd3:    return phase - 2'd1;
            default: return phase + 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/cdr_edge_hist.sv
// Per-word edge detection and edge-position histogram over a fixed window of words.
module cdr_edge_hist
    import cdr_pkg::*;
#(
    parameter int WINDOW_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       win_close,
    output phase_t     edge_pos,
    output logic       win_empty,
    output logic       prev3
);

    localparam int CW = WINDOW_LOG2 + 1;

    logic [3:0][CW-1:0]       r_cnt;
    logic [WINDOW_LOG2-1:0]   r_wordCnt;
    logic                     r_prev3;

    logic [3:0]               w_edges;
    logic [3:0][CW-1:0]       w_cntNext;
    logic [CW-1:0]            w_bestVal;

    assign w_edges = in_data ^ {in_data[2:0], r_prev3};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cntNext[i] = r_cnt[i] + {{(CW-1){1'b0}}, w_edges[i]};
        end
    end

    // The closing word's edges are part of the decision, so argmax runs on the updated counts.
    always_comb begin
        edge_pos  = '0;
        w_bestVal = w_cntNext[0];
        for (int i = 1; i < 4; i++) begin
            if (w_cntNext[i] > w_bestVal) begin
                w_bestVal = w_cntNext[i];
                edge_pos  = phase_t'(i);
            end
        end
    end

    assign win_close = in_valid && (r_wordCnt == '1);
    assign win_empty = (w_cntNext == '0);
    assign prev3     = r_prev3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wordCnt <= '0;
            r_prev3   <= 1'b0;
        end else if (in_valid) begin
            r_prev3   <= in_data[3];
            r_wordCnt <= r_wordCnt + 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= win_close ? '0 : w_cntNext[i];
            end
        end
    end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR phase-selection controller: chooses the eye-centre sample phase and emits recovered bits.
module cdr_phase_ctrl
    import cdr_pkg::*;
#(
    parameter int WINDOW_LOG2  = 4,
    parameter int LOCK_WINDOWS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       out_valid,
    output logic [1:0] out_num,
    output logic [1:0] out_data,
    output logic       out_locked,
    output logic [1:0] out_phase
);

    cdr_state_t            r_state, w_stateNext;
    phase_t                r_phase, w_phaseNext;
    logic [STABLE_W-1:0]   r_stableCnt, w_stableNext;
    slip_t                 r_slip, w_slipNext;

    logic                  r_outValid, w_outValid;
    logic [1:0]            r_outNum, w_outNum;
    logic [1:0]            r_outData, w_outData;

    logic                  w_winClose;
    logic                  w_winEmpty;
    logic                  w_prev3;
    phase_t                w_edgePos;
    phase_t                w_target;

    cdr_edge_hist #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .win_close (w_winClose),
        .edge_pos  (w_edgePos),
        .win_empty (w_winEmpty),
        .prev3     (w_prev3)
    );

    assign w_target = w_edgePos + 2'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACQUIRE;
            r_phase     <= RESET_PHASE;
            r_stableCnt <= '0;
            r_slip      <= SLIP_NONE;
        end else begin
            r_state     <= w_stateNext;
            r_phase     <= w_phaseNext;
            r_stableCnt <= w_stableNext;
            r_slip      <= w_slipNext;
        end
    end

    // An empty window leaves phase, stable count and lock untouched.
    always_comb begin
        w_stateNext  = r_state;
        w_phaseNext  = r_phase;
        w_stableNext = r_stableCnt;
        w_slipNext   = r_slip;
        if (in_valid) begin
            w_slipNext = SLIP_NONE;
            if (w_winClose && !w_winEmpty) begin
                if (w_target == r_phase) begin
                    if (r_stableCnt != '1) begin
                        w_stableNext = r_stableCnt + 1'b1;
                    end
                    if (w_stableNext >= STABLE_W'(LOCK_WINDOWS)) begin
                        w_stateNext = LOCKED;
                    end
                end else begin
                    w_phaseNext  = phase_step(r_phase, w_target);
                    w_stableNext = '0;
                    w_stateNext  = ACQUIRE;
                    if (r_phase == 2'd3 && w_phaseNext == 2'd0) begin
                        w_slipNext = SLIP_DROP;
                    end else if (r_phase == 2'd0 && w_phaseNext == 2'd3) begin
                        w_slipNext = SLIP_DOUBLE;
                    end
                end
            end
        end
    end

    // Wrapping 3->0 re-samples a bit already emitted; wrapping 0->3 would skip one.
    always_comb begin
        w_outValid = 1'b0;
        w_outNum   = 2'd0;
        w_outData  = 2'd0;
        if (in_valid) begin
            case (r_slip)
                SLIP_DROP: begin
                    w_outValid = 1'b0;
                end
                SLIP_DOUBLE: begin
                    w_outValid = 1'b1;
                    w_outNum   = 2'd2;
                    w_outData  = {in_data[3], w_prev3};
                end
                default: begin
                    w_outValid = 1'b1;
                    w_outNum   = 2'd1;
                    w_outData  = {1'b0, in_data[r_phase]};
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outNum   <= 2'd0;
            r_outData  <= 2'd0;
        end else begin
            r_outValid <= w_outValid;
            r_outNum   <= w_outNum;
            r_outData  <= w_outData;
        end
    end

    assign out_valid  = r_outValid;
    assign out_num    = r_outNum;
    assign out_data   = r_outData;
    assign out_locked = (r_state == LOCKED);
    assign out_phase  = r_phase;

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// Self-checking bench for cdr_phase_ctrl: behavioural model feeds a scoreboard queue.
module tb_cdr_phase_ctrl;

    localparam int WL2 = 4;
    localparam int LW  = 2;
    localparam int WIN = 1 << WL2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_valid;
    logic [1:0] out_num;
    logic [1:0] out_data;
    logic       out_locked;
    logic [1:0] out_phase;

    typedef struct packed {
        logic       v;
        logic [1:0] n;
        logic [1:0] d;
        logic [1:0] p;
        logic       l;
    } exp_t;

    exp_t expQ[$];

    int checkCount = 0;
    int failCount  = 0;

    int   mPhase, mStable, mWord, mSlip;
    int   mHist[4];
    logic mPrev3;
    logic mLocked;

    cdr_phase_ctrl #(
        .WINDOW_LOG2  (WL2),
        .LOCK_WINDOWS (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_num    (out_num),
        .out_data   (out_data),
        .out_locked (out_locked),
        .out_phase  (out_phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase  = 2;
        mStable = 0;
        mWord   = 0;
        mSlip   = 0;
        mPrev3  = 1'b0;
        mLocked = 1'b0;
        for (int i = 0; i < 4; i++) mHist[i] = 0;
        expQ.delete();
    endtask

    // Reference behaviour for one accepted word; pushes the expected output.
    task automatic modelWord(input logic [3:0] s);
        exp_t       e;
        logic [3:0] edg;
        int         best, target, diff, newP;
        e = '0;
        if (mSlip == 1) begin
            e.v = 1'b0;
        end else if (mSlip == 2) begin
            e.v = 1'b1;
            e.n = 2'd2;
            e.d = {s[3], mPrev3};
        end else begin
            e.v = 1'b1;
            e.n = 2'd1;
            e.d = {1'b0, s[mPhase]};
        end
        mSlip  = 0;
        edg[0] = s[0] ^ mPrev3;
        for (int i = 1; i < 4; i++) edg[i] = s[i] ^ s[i-1];
        for (int i = 0; i < 4; i++) mHist[i] += int'(edg[i]);
        mPrev3 = s[3];
        mWord++;
        if (mWord == WIN) begin
            mWord = 0;
            best  = 0;
            for (int i = 1; i < 4; i++) if (mHist[i] > mHist[best]) best = i;
            if (mHist[best] != 0) begin
                target = (best + 2) % 4;
                if (target == mPhase) begin
                    if (mStable < 7) mStable++;
                    if (mStable >= LW) mLocked = 1'b1;
                end else begin
                    diff = (target - mPhase + 4) % 4;
                    newP = (diff == 3) ? (mPhase + 3) % 4 : (mPhase + 1) % 4;
                    if (mPhase == 3 && newP == 0) mSlip = 1;
                    else if (mPhase == 0 && newP == 3) mSlip = 2;
                    mPhase  = newP;
                    mStable = 0;
                    mLocked = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) mHist[i] = 0;
        end
        e.p = 2'(mPhase);
        e.l = mLocked;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic v);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (v) modelWord(d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(4'($urandom_range(0, 15)), 1'b0);
    endtask

    // Alternating two-word pattern, starting with a, with random idle gaps.
    task automatic drivePattern(input logic [3:0] a, input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            applyStimulus((k % 2 == 0) ? a : b, 1'b1);
        end
    endtask

    // Scoreboard: one expected entry per accepted word, compared one cycle later.
    initial begin
        exp_t e;
        logic sv, sr;
        forever begin
            @(posedge clk);
            sv = in_valid;
            sr = rst;
            #1;
            if (!sr) begin
                if (sv) begin
                    if (expQ.size() == 0) begin
                        checkOutput("queue_underflow", 32'd0, 32'd1);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("sb_valid",  out_valid,  e.v);
                        checkOutput("sb_num",    out_num,    e.n);
                        checkOutput("sb_data",   out_data,   e.d);
                        checkOutput("sb_phase",  out_phase,  e.p);
                        checkOutput("sb_locked", out_locked, e.l);
                    end
                end else begin
                    checkOutput("idle_valid",  out_valid,  32'd0);
                    checkOutput("idle_phase",  out_phase,  mPhase);
                    checkOutput("idle_locked", out_locked, mLocked);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid",  out_valid,  32'd0);
        checkOutput("rst_num",    out_num,    32'd0);
        checkOutput("rst_data",   out_data,   32'd0);
        checkOutput("rst_locked", out_locked, 32'd0);
        checkOutput("rst_phase",  out_phase,  32'd2);
        @(negedge clk);
        rst = 1'b0;

        idle(20);
        checkOutput("idle_hold_phase", out_phase, 32'd2);

        $display("[TB] clean 0000/1111 stream, edges at index 0");
        drivePattern(4'b0000, 4'b1111, 2 * WIN - 1);
        idle(1);
        checkOutput("pre_lock", out_locked, 32'd0);
        applyStimulus(4'b1111, 1'b1);
        idle(1);
        checkOutput("lock_word32", out_locked, 32'd1);
        checkOutput("lock_phase",  out_phase,  32'd2);

        $display("[TB] constant zero for three windows");
        drivePattern(4'b0000, 4'b0000, 3 * WIN);
        idle(1);
        checkOutput("zero_phase",  out_phase,  32'd2);
        checkOutput("zero_locked", out_locked, 32'd1);

        $display("[TB] edges at index 1 from phase 2");
        drivePattern(4'b1110, 4'b0001, WIN);
        idle(1);
        checkOutput("step_up_phase",  out_phase,  32'd3);
        checkOutput("step_up_locked", out_locked, 32'd0);
        drivePattern(4'b1110, 4'b0001, WIN);
        idle(1);
        checkOutput("relock_one_win", out_locked, 32'd0);
        drivePattern(4'b1110, 4'b0001, WIN);
        idle(1);
        checkOutput("relock_two_win", out_locked, 32'd1);

        $display("[TB] edges at index 2 from phase 3");
        drivePattern(4'b1100, 4'b0011, WIN);
        idle(1);
        checkOutput("wrap_up_phase", out_phase, 32'd0);
        applyStimulus(4'b1100, 1'b1);
        idle(1);
        checkOutput("drop_valid", out_valid, 32'd0);
        applyStimulus(4'b0011, 1'b1);
        idle(1);
        checkOutput("after_drop_num",  out_num,  32'd1);
        checkOutput("after_drop_data", out_data, 32'd1);
        drivePattern(4'b1100, 4'b0011, WIN - 2);
        idle(1);
        checkOutput("hold_phase0", out_phase, 32'd0);

        $display("[TB] edges at index 1 from phase 0");
        drivePattern(4'b1110, 4'b0001, WIN);
        idle(1);
        checkOutput("wrap_down_phase", out_phase, 32'd3);
        applyStimulus(4'b1110, 1'b1);
        idle(1);
        checkOutput("double_valid", out_valid, 32'd1);
        checkOutput("double_num",   out_num,   32'd2);
        checkOutput("double_data",  out_data,  32'd2);
        applyStimulus(4'b0001, 1'b1);
        idle(1);
        checkOutput("after_double_num",  out_num,  32'd1);
        checkOutput("after_double_data", out_data, 32'd0);

        $display("[TB] reset mid-window");
        drivePattern(4'b1100, 4'b0011, 5);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_valid",  out_valid,  32'd0);
        checkOutput("midrst_num",    out_num,    32'd0);
        checkOutput("midrst_data",   out_data,   32'd0);
        checkOutput("midrst_locked", out_locked, 32'd0);
        checkOutput("midrst_phase",  out_phase,  32'd2);
        @(posedge clk);
        #1;
        checkOutput("midrst_phase_edge", out_phase, 32'd2);
        @(negedge clk);
        rst = 1'b0;
        drivePattern(4'b1110, 4'b0001, WIN);
        idle(1);
        checkOutput("post_rst_window", out_phase, 32'd3);
        idle(2);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
